// File: rtl/vga_timing_gen.sv
// vga_timing_gen: run-time selectable VGA/VESA raster timing generator.
// Generates pixel coordinates, sync pulses with per-mode polarity, a
// video-active flag and line/frame strobes. All outputs are registered from
// the same counter value, so they stay mutually aligned one cycle behind the
// counters. A requested mode change is applied only while idle or on the
// last pixel of a frame, so the display never sees a torn frame.
`timescale 1ns/1ps
module vga_timing_gen #(
  parameter int CW           = 12,
  parameter int DEFAULT_MODE = 0
) (
  input  logic          sclk,
  input  logic          rst_n,
  input  logic          enable,
  input  logic [1:0]    mode,
  output logic [CW-1:0] X_PIX,
  output logic [CW-1:0] Y_PIX,
  output logic          Video_On,
  output logic          HSync,
  output logic          VSync,
  output logic          line_start,
  output logic          frame_start,
  output logic [1:0]    mode_active
);

  // Mode 3 has htot-1 = 1649, which needs 11 bits of counter.
  if (CW < 11) begin : g_cw_check
    $error("vga_timing_gen: CW must be at least 11 to hold the largest mode");
  end
  if (DEFAULT_MODE < 0 || DEFAULT_MODE > 3) begin : g_mode_check
    $error("vga_timing_gen: DEFAULT_MODE must be in 0..3");
  end

  // Pre-summed boundaries so the per-pixel compares are plain CW-bit compares.
  typedef struct packed {
    logic [CW-1:0] hres;
    logic [CW-1:0] hs_start;
    logic [CW-1:0] hs_end;
    logic [CW-1:0] htot;
    logic [CW-1:0] vres;
    logic [CW-1:0] vs_start;
    logic [CW-1:0] vs_end;
    logic [CW-1:0] vtot;
    logic          pos_pol;
  } timing_t;

  // 800x600 and 1280x720 use active-high syncs; the other two are active-low.
  function automatic logic is_pos_pol(input logic [1:0] m);
    return (m == 2'd1) || (m == 2'd3);
  endfunction

  function automatic timing_t mode_timing(input logic [1:0] m);
    timing_t       t;
    logic [CW-1:0] hfp, hsp, hbp, vfp, vsp, vbp;
    t   = '0;
    hfp = '0; hsp = '0; hbp = '0;
    vfp = '0; vsp = '0; vbp = '0;
    case (m)
      2'd0: begin
        t.hres = CW'(640);  hfp = CW'(16);  hsp = CW'(96);  hbp = CW'(48);
        t.vres = CW'(480);  vfp = CW'(10);  vsp = CW'(2);   vbp = CW'(33);
      end
      2'd1: begin
        t.hres = CW'(800);  hfp = CW'(40);  hsp = CW'(128); hbp = CW'(88);
        t.vres = CW'(600);  vfp = CW'(1);   vsp = CW'(4);   vbp = CW'(23);
      end
      2'd2: begin
        t.hres = CW'(1024); hfp = CW'(24);  hsp = CW'(136); hbp = CW'(160);
        t.vres = CW'(768);  vfp = CW'(3);   vsp = CW'(6);   vbp = CW'(29);
      end
      2'd3: begin
        t.hres = CW'(1280); hfp = CW'(110); hsp = CW'(40);  hbp = CW'(220);
        t.vres = CW'(720);  vfp = CW'(5);   vsp = CW'(5);   vbp = CW'(20);
      end
    endcase
    t.hs_start = t.hres + hfp;
    t.hs_end   = t.hs_start + hsp;
    t.htot     = t.hs_end + hbp;
    t.vs_start = t.vres + vfp;
    t.vs_end   = t.vs_start + vsp;
    t.vtot     = t.vs_end + vbp;
    t.pos_pol  = is_pos_pol(m);
    return t;
  endfunction

  localparam logic [1:0] DEF_MODE      = 2'(DEFAULT_MODE);
  localparam logic       DEF_IDLE_SYNC = ~is_pos_pol(DEF_MODE);

  logic [CW-1:0] h_cnt;
  logic [CW-1:0] v_cnt;
  timing_t       cur;
  logic          req_pos;
  logic          h_last;
  logic          v_last;
  logic          h_in_sync;
  logic          v_in_sync;

  // Timing of the mode being generated; the requested mode only matters
  // for the idle sync level.
  always_comb begin
    cur       = mode_timing(mode_active);
    req_pos   = is_pos_pol(mode);
    // >= rather than == so an out-of-range count can never run away.
    h_last    = (h_cnt >= cur.htot - CW'(1));
    v_last    = (v_cnt >= cur.vtot - CW'(1));
    h_in_sync = (h_cnt >= cur.hs_start) && (h_cnt < cur.hs_end);
    v_in_sync = (v_cnt >= cur.vs_start) && (v_cnt < cur.vs_end);
  end

  // Raster counters and active mode; mode is swapped only when idle or at
  // the frame-end wrap so the new timing begins at counter 0.
  always_ff @(posedge sclk or negedge rst_n) begin
    if (!rst_n) begin
      h_cnt       <= '0;
      v_cnt       <= '0;
      mode_active <= DEF_MODE;
    end else if (!enable) begin
      h_cnt       <= '0;
      v_cnt       <= '0;
      mode_active <= mode;
    end else if (h_last) begin
      h_cnt <= '0;
      if (v_last) begin
        v_cnt       <= '0;
        mode_active <= mode;
      end else begin
        v_cnt <= v_cnt + CW'(1);
      end
    end else begin
      h_cnt <= h_cnt + CW'(1);
    end
  end

  // Registered pixel-pipeline outputs, all decoded from the same count.
  always_ff @(posedge sclk or negedge rst_n) begin
    if (!rst_n) begin
      X_PIX       <= '0;
      Y_PIX       <= '0;
      Video_On    <= 1'b0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      HSync       <= DEF_IDLE_SYNC;
      VSync       <= DEF_IDLE_SYNC;
    end else if (!enable) begin
      X_PIX       <= '0;
      Y_PIX       <= '0;
      Video_On    <= 1'b0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      HSync       <= ~req_pos;
      VSync       <= ~req_pos;
    end else begin
      X_PIX       <= h_cnt;
      Y_PIX       <= v_cnt;
      Video_On    <= (h_cnt < cur.hres) && (v_cnt < cur.vres);
      line_start  <= (h_cnt == '0);
      frame_start <= (h_cnt == '0) && (v_cnt == '0);
      HSync       <= h_in_sync ? cur.pos_pol : ~cur.pos_pol;
      VSync       <= v_in_sync ? cur.pos_pol : ~cur.pos_pol;
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: directed mode/enable/reset scenarios plus random
// segments, every cycle compared against a raster model built on the elapsed
// pixel count of the current frame.
`timescale 1ns/1ps
module tb_vga_timing_gen;
  localparam int CW = 12;

  localparam int HRES [4] = '{640, 800, 1024, 1280};
  localparam int HFP  [4] = '{16, 40, 24, 110};
  localparam int HSP  [4] = '{96, 128, 136, 40};
  localparam int HBP  [4] = '{48, 88, 160, 220};
  localparam int VRES [4] = '{480, 600, 768, 720};
  localparam int VFP  [4] = '{10, 1, 3, 5};
  localparam int VSP  [4] = '{2, 4, 6, 5};
  localparam int VBP  [4] = '{33, 23, 29, 20};
  localparam int POS  [4] = '{0, 1, 0, 1};

  logic          sclk = 1'b0;
  logic          rst_n;
  logic          enable;
  logic [1:0]    mode;
  logic [CW-1:0] X_PIX, Y_PIX;
  logic          Video_On, HSync, VSync, line_start, frame_start;
  logic [1:0]    mode_active;

  vga_timing_gen #(.CW(CW), .DEFAULT_MODE(0)) dut (
    .sclk(sclk), .rst_n(rst_n), .enable(enable), .mode(mode),
    .X_PIX(X_PIX), .Y_PIX(Y_PIX), .Video_On(Video_On), .HSync(HSync),
    .VSync(VSync), .line_start(line_start), .frame_start(frame_start),
    .mode_active(mode_active)
  );

  always #5 sclk = ~sclk;

  int n_cmp = 0;
  int n_err = 0;

  // model state: mode being generated and pixels elapsed in current frame
  int mode_m, t_m;
  int ex, ey, ev, ehs, evs, els, efs;
  // per-segment tallies of observed outputs
  int ls_cnt, von_cnt, hs_hi, hs_lo, vs_act;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mode_m = 0; t_m = 0;
    ex = 0; ey = 0; ev = 0; els = 0; efs = 0;
    ehs = 1; evs = 1;
  endtask

  task automatic model_step(input int en, input int md);
    int htot, vtot, h, v;
    if (en == 0) begin
      ex = 0; ey = 0; ev = 0; els = 0; efs = 0;
      ehs = 1 - POS[md]; evs = 1 - POS[md];
      mode_m = md; t_m = 0;
    end else begin
      htot = HRES[mode_m] + HFP[mode_m] + HSP[mode_m] + HBP[mode_m];
      vtot = VRES[mode_m] + VFP[mode_m] + VSP[mode_m] + VBP[mode_m];
      h = t_m % htot;
      v = t_m / htot;
      ex = h; ey = v;
      ev  = (h < HRES[mode_m] && v < VRES[mode_m]) ? 1 : 0;
      ehs = (h >= HRES[mode_m] + HFP[mode_m] && h < HRES[mode_m] + HFP[mode_m] + HSP[mode_m])
            ? POS[mode_m] : 1 - POS[mode_m];
      evs = (v >= VRES[mode_m] + VFP[mode_m] && v < VRES[mode_m] + VFP[mode_m] + VSP[mode_m])
            ? POS[mode_m] : 1 - POS[mode_m];
      els = (h == 0) ? 1 : 0;
      efs = (t_m == 0) ? 1 : 0;
      t_m++;
      if (t_m == htot * vtot) begin
        t_m = 0;
        mode_m = md;
      end
    end
  endtask

  task automatic check_all();
    check("X_PIX", X_PIX, ex);
    check("Y_PIX", Y_PIX, ey);
    check("Video_On", Video_On, ev);
    check("HSync", HSync, ehs);
    check("VSync", VSync, evs);
    check("line_start", line_start, els);
    check("frame_start", frame_start, efs);
    check("mode_active", mode_active, mode_m);
  endtask

  task automatic clear_tally();
    ls_cnt = 0; von_cnt = 0; hs_hi = 0; hs_lo = 0; vs_act = 0;
  endtask

  task automatic tick(input int en, input int md);
    enable = (en != 0);
    mode   = md[1:0];
    @(posedge sclk);
    model_step(en, md);
    #1;
    check_all();
    if (en != 0) begin
      ls_cnt  += int'(line_start);
      von_cnt += int'(Video_On);
      hs_hi   += int'(HSync);
      hs_lo   += int'(!HSync);
      vs_act  += (int'(VSync) == POS[mode_active]) ? 1 : 0;
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int guard;
    rst_n = 1'b0; enable = 1'b0; mode = 2'd0;
    model_reset();
    repeat (2) @(posedge sclk);
    #3;
    check_all();

    // Mode 0 from reset: three full lines
    rst_n = 1'b1;
    clear_tally();
    for (int i = 0; i < 2400; i++) tick(1, 0);
    check("m0_line_starts", ls_cnt, 3);
    check("m0_hsync_low", hs_lo, 3 * 96);
    check("m0_video_on", von_cnt, 3 * 640);
    check("m0_vsync_active", vs_act, 0);

    // Mid-frame request for mode 1 is held off
    clear_tally();
    for (int i = 0; i < 1000; i++) tick(1, 1);
    check("m0_hold_mode", mode_active, 0);
    check("m0_hold_hsync_low", hs_lo, 96);

    // Drop enable at X_PIX=300, then restart
    guard = 0;
    while (ex != 300 && guard < 2000) begin
      tick(1, 0);
      guard++;
    end
    check("reach_x300", ex, 300);
    tick(0, 3);
    check("idle_x", X_PIX, 0);
    check("idle_hsync_m3", HSync, 0);
    check("idle_mode_load", mode_active, 3);
    tick(1, 3);
    check("restart_fs", frame_start, 1);
    check("restart_ls", line_start, 1);

    // Mode 3: two lines
    clear_tally();
    for (int i = 0; i < 1650 * 2 - 1; i++) tick(1, 3);
    check("m3_line_starts", ls_cnt, 1);
    check("m3_hsync_high", hs_hi, 2 * 40);

    // Mode 1 and mode 2 via an idle cycle
    tick(0, 1);
    clear_tally();
    for (int i = 0; i < 1056 * 2; i++) tick(1, 1);
    check("m1_line_starts", ls_cnt, 2);
    check("m1_hsync_high", hs_hi, 2 * 128);
    tick(0, 2);
    clear_tally();
    for (int i = 0; i < 1344; i++) tick(1, 2);
    check("m2_hsync_low", hs_lo, 136);
    for (int i = 0; i < 500; i++) tick(1, 2);
    check("m2_pre_reset_x", X_PIX, 499);

    // Asynchronous reset between clock edges
    #3;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all();
    @(posedge sclk);
    #1;
    check_all();
    rst_n = 1'b1;
    clear_tally();
    for (int i = 0; i < 1600; i++) tick(1, 2);
    check("post_rst_line_starts", ls_cnt, 2);
    check("post_rst_mode", mode_active, 0);

    // Random segments
    for (int s = 0; s < 24; s++) begin
      int m, idle, len;
      m    = $urandom_range(0, 3);
      idle = $urandom_range(1, 3);
      len  = $urandom_range(1, 1800);
      for (int i = 0; i < idle; i++) tick(0, m);
      for (int i = 0; i < len; i++) tick(1, $urandom_range(0, 3));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
